// File: rtl/alu_instr_sequencer.sv
// Control sequencer for three-register ALU instructions on the bus-based datapath.
// Walks T0-T5 per instruction with a memory-ready wait in T1, opcode trapping and run/step modes.
module alu_instr_sequencer #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned NUM_REGS    = 16,
  parameter int unsigned SEL_WIDTH   = 4,
  parameter int unsigned OPC_WIDTH   = 5,
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  start,
  input  logic                  run,
  input  logic                  mem_ready,
  input  logic [DATA_WIDTH-1:0] IR,
  output logic                  PCout,
  output logic                  Zlowout,
  output logic                  MDRout,
  output logic                  MARin,
  output logic                  Zin,
  output logic                  PCin,
  output logic                  MDRin,
  output logic                  IRin,
  output logic                  Yin,
  output logic                  IncPC,
  output logic                  Read,
  output logic [NUM_REGS-1:0]   Rin,
  output logic [NUM_REGS-1:0]   Rout,
  output logic [2:0]            alu_op,
  output logic                  busy,
  output logic                  done,
  output logic                  illegal_op,
  output logic                  mem_error
);

  localparam int unsigned RA_MSB  = DATA_WIDTH - OPC_WIDTH - 1;
  localparam int unsigned RB_MSB  = RA_MSB - SEL_WIDTH;
  localparam int unsigned RC_MSB  = RB_MSB - SEL_WIDTH;
  localparam int unsigned LOW_MSB = RC_MSB - SEL_WIDTH;
  localparam int unsigned CNT_W   = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5
  } state_e;

  state_e             state_q;
  logic [CNT_W-1:0]   wait_cnt_q;
  logic               illegal_op_q;
  logic               mem_error_q;

  logic [OPC_WIDTH-1:0] op;
  logic [SEL_WIDTH-1:0] ra, rb, rc;
  logic                 op_legal;
  logic [2:0]           op_code;
  logic                 unused_ir_low;

  assign op            = IR[DATA_WIDTH-1 -: OPC_WIDTH];
  assign ra            = IR[RA_MSB -: SEL_WIDTH];
  assign rb            = IR[RB_MSB -: SEL_WIDTH];
  assign rc            = IR[RC_MSB -: SEL_WIDTH];
  assign unused_ir_low = ^IR[LOW_MSB:0];

  // Select fields at or beyond NUM_REGS address nothing.
  function automatic logic [NUM_REGS-1:0] sel_onehot(input logic [SEL_WIDTH-1:0] sel);
    logic [NUM_REGS-1:0] oh;
    oh = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      oh[i] = (32'(sel) == i);
    end
    return oh;
  endfunction

  always_comb begin
    op_code = 3'd0;
    case (op)
      OPC_WIDTH'(3): op_code = 3'd1;
      OPC_WIDTH'(4): op_code = 3'd2;
      OPC_WIDTH'(5): op_code = 3'd3;
      OPC_WIDTH'(6): op_code = 3'd4;
      default:       op_code = 3'd0;
    endcase
  end

  assign op_legal = (op_code != 3'd0);

  // State, T1 wait counter and sticky error flags.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q      <= S_IDLE;
      wait_cnt_q   <= '0;
      illegal_op_q <= 1'b0;
      mem_error_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q      <= S_T0;
            wait_cnt_q   <= '0;
            illegal_op_q <= 1'b0;
            mem_error_q  <= 1'b0;
          end
        end
        S_T0: state_q <= S_T1;
        S_T1: begin
          if (mem_ready) begin
            state_q    <= S_T2;
            wait_cnt_q <= '0;
          end else if (wait_cnt_q == CNT_W'(MEM_TIMEOUT - 1)) begin
            state_q     <= S_IDLE;
            wait_cnt_q  <= '0;
            mem_error_q <= 1'b1;
          end else begin
            wait_cnt_q <= wait_cnt_q + CNT_W'(1);
          end
        end
        S_T2: state_q <= S_T3;
        S_T3: begin
          if (op_legal) begin
            state_q <= S_T4;
          end else begin
            state_q      <= S_IDLE;
            illegal_op_q <= 1'b1;
          end
        end
        S_T4: state_q <= S_T5;
        S_T5: state_q <= run ? S_T0 : S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Strobes decode directly from the registered state and IR fields.
  always_comb begin
    PCout   = 1'b0;
    Zlowout = 1'b0;
    MDRout  = 1'b0;
    MARin   = 1'b0;
    Zin     = 1'b0;
    PCin    = 1'b0;
    MDRin   = 1'b0;
    IRin    = 1'b0;
    Yin     = 1'b0;
    IncPC   = 1'b0;
    Read    = 1'b0;
    Rin     = '0;
    Rout    = '0;
    alu_op  = 3'd0;
    done    = 1'b0;
    case (state_q)
      S_T0: begin
        PCout = 1'b1;
        MARin = 1'b1;
        IncPC = 1'b1;
        Zin   = 1'b1;
      end
      S_T1: begin
        Zlowout = 1'b1;
        PCin    = 1'b1;
        Read    = 1'b1;
        MDRin   = 1'b1;
      end
      S_T2: begin
        MDRout = 1'b1;
        IRin   = 1'b1;
      end
      S_T3: begin
        Rout = sel_onehot(rb);
        Yin  = 1'b1;
      end
      S_T4: begin
        Rout   = sel_onehot(rc);
        Zin    = 1'b1;
        alu_op = op_code;
      end
      S_T5: begin
        Zlowout = 1'b1;
        Rin     = sel_onehot(ra);
        done    = 1'b1;
      end
      default: ;
    endcase
  end

  assign busy       = (state_q != S_IDLE);
  assign illegal_op = illegal_op_q;
  assign mem_error  = mem_error_q;

endmodule

// File: tb/tb_alu_instr_sequencer.sv
// Directed bench for alu_instr_sequencer: one task per scenario, inline checks.
module tb_alu_instr_sequencer;

  logic        Clock = 1'b0;
  logic        Reset, start, run, mem_ready;
  logic [31:0] IR;
  logic        PCout, Zlowout, MDRout, MARin, Zin, PCin, MDRin, IRin, Yin, IncPC, Read;
  logic [15:0] Rin, Rout;
  logic [2:0]  alu_op;
  logic        busy, done, illegal_op, mem_error;
  logic [10:0] strobes;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [31:0] IR_AND = 32'h2891_8000;
  localparam logic [31:0] IR_ADD = 32'h1891_8000;
  localparam logic [31:0] IR_BAD = 32'hF891_8000;

  always #5 Clock = ~Clock;

  assign strobes = {PCout, Zlowout, MDRout, MARin, Zin, PCin, MDRin, IRin, Yin, IncPC, Read};

  alu_instr_sequencer dut (
    .Clock(Clock), .Reset(Reset), .start(start), .run(run), .mem_ready(mem_ready), .IR(IR),
    .PCout(PCout), .Zlowout(Zlowout), .MDRout(MDRout), .MARin(MARin), .Zin(Zin), .PCin(PCin),
    .MDRin(MDRin), .IRin(IRin), .Yin(Yin), .IncPC(IncPC), .Read(Read),
    .Rin(Rin), .Rout(Rout), .alu_op(alu_op), .busy(busy), .done(done),
    .illegal_op(illegal_op), .mem_error(mem_error)
  );

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int k;
    k = 0;
    while (busy && k < 40) begin
      step();
      k++;
    end
    n_checks++;
    if (busy !== 1'b0) begin
      $display("FAIL %s_idle: busy=%b required 0", tag, busy);
      n_fail++;
    end
  endtask

  task automatic test_reset();
    Reset = 1'b1; start = 1'b0; run = 1'b0; mem_ready = 1'b0; IR = '0;
    step();
    step();
    Reset = 1'b0;
    step();
    n_checks++; if (busy !== 1'b0) begin $display("FAIL reset_busy: got %b want 0", busy); n_fail++; end
    n_checks++; if (strobes !== 11'd0) begin $display("FAIL reset_strobes: got %h want 0", strobes); n_fail++; end
    n_checks++; if ((Rin | Rout) !== 16'd0) begin $display("FAIL reset_regs: Rin=%h Rout=%h want 0", Rin, Rout); n_fail++; end
    n_checks++; if (alu_op !== 3'd0) begin $display("FAIL reset_alu_op: got %0d want 0", alu_op); n_fail++; end
    n_checks++; if ({illegal_op, mem_error, done} !== 3'b000) begin
      $display("FAIL reset_flags: illegal=%b mem_err=%b done=%b want 000", illegal_op, mem_error, done); n_fail++; end
  endtask

  task automatic test_and();
    IR = IR_AND; mem_ready = 1'b1; run = 1'b0;
    pulse_start();
    for (int c = 1; c <= 7; c++) begin
      n_checks++;
      if (done !== (c == 6)) begin $display("FAIL and_done_c%0d: got %b want %b", c, done, (c == 6)); n_fail++; end
      if (c == 1) begin
        n_checks++; if ({PCout, MARin, IncPC, Zin} !== 4'hF) begin $display("FAIL and_t0: got %b want 1111", {PCout, MARin, IncPC, Zin}); n_fail++; end
      end
      if (c == 3) begin
        n_checks++; if (IRin !== 1'b1) begin $display("FAIL and_t2_irin: got %b want 1", IRin); n_fail++; end
      end
      if (c == 4) begin
        n_checks++; if ({Rout, Yin} !== {16'h0004, 1'b1}) begin $display("FAIL and_t3: Rout=%h Yin=%b want 0004/1", Rout, Yin); n_fail++; end
      end
      if (c == 5) begin
        n_checks++; if ({Rout, alu_op, Zin} !== {16'h0008, 3'd3, 1'b1}) begin
          $display("FAIL and_t4: Rout=%h alu_op=%0d Zin=%b want 0008/3/1", Rout, alu_op, Zin); n_fail++; end
      end
      if (c == 6) begin
        n_checks++; if ({Rin, Rout} !== {16'h0002, 16'h0000}) begin $display("FAIL and_t5: Rin=%h Rout=%h want 0002/0000", Rin, Rout); n_fail++; end
      end
      if (c == 7) begin
        n_checks++; if (busy !== 1'b0) begin $display("FAIL and_idle: busy=%b want 0", busy); n_fail++; end
      end
      if (c < 7) step();
    end
  endtask

  task automatic test_mem_wait();
    int cyc, rd, done_at;
    IR = IR_AND; run = 1'b0; mem_ready = 1'b0;
    pulse_start();
    cyc = 1; rd = 0; done_at = 0;
    while (cyc <= 12 && done_at == 0) begin
      if (Read && MDRin) rd++;
      if (done) done_at = cyc;
      step();
      cyc++;
      mem_ready = (cyc >= 5);
    end
    n_checks++; if (rd !== 4) begin $display("FAIL wait_read_cycles: got %0d want 4", rd); n_fail++; end
    n_checks++; if (done_at !== 9) begin $display("FAIL wait_done_cycle: got %0d want 9", done_at); n_fail++; end
    n_checks++; if (busy !== 1'b0) begin $display("FAIL wait_idle: busy=%b want 0", busy); n_fail++; end
    mem_ready = 1'b1;
  endtask

  task automatic test_timeout();
    int cyc, rd, irin, idle_at;
    IR = IR_AND; run = 1'b0; mem_ready = 1'b0;
    pulse_start();
    cyc = 1; rd = 0; irin = 0; idle_at = 0;
    while (cyc <= 30 && idle_at == 0) begin
      if (Read) rd++;
      if (IRin) irin++;
      if (!busy) idle_at = cyc;
      else begin
        step();
        cyc++;
      end
    end
    n_checks++; if (rd !== 15) begin $display("FAIL timeout_t1_cycles: got %0d want 15", rd); n_fail++; end
    n_checks++; if (idle_at !== 17) begin $display("FAIL timeout_idle_cycle: got %0d want 17", idle_at); n_fail++; end
    n_checks++; if (irin !== 0) begin $display("FAIL timeout_irin: got %0d want 0", irin); n_fail++; end
    n_checks++; if (mem_error !== 1'b1) begin $display("FAIL timeout_mem_error: got %b want 1", mem_error); n_fail++; end
    n_checks++; if (illegal_op !== 1'b0) begin $display("FAIL timeout_illegal: got %b want 0", illegal_op); n_fail++; end
    mem_ready = 1'b1;
  endtask

  task automatic test_illegal();
    logic [15:0] rin_seen;
    IR = IR_BAD; mem_ready = 1'b1; run = 1'b0;
    pulse_start();
    n_checks++; if (mem_error !== 1'b0) begin $display("FAIL illegal_clears_mem_error: got %b want 0", mem_error); n_fail++; end
    rin_seen = '0;
    for (int c = 1; c <= 5; c++) begin
      rin_seen |= Rin;
      if (c == 4) begin
        n_checks++; if ({Yin, Rout} !== {1'b1, 16'h0004}) begin $display("FAIL illegal_t3: Yin=%b Rout=%h want 1/0004", Yin, Rout); n_fail++; end
      end
      if (c == 5) begin
        n_checks++; if (busy !== 1'b0) begin $display("FAIL illegal_idle: busy=%b want 0", busy); n_fail++; end
        n_checks++; if (illegal_op !== 1'b1) begin $display("FAIL illegal_flag: got %b want 1", illegal_op); n_fail++; end
      end
      if (c < 5) step();
    end
    n_checks++; if (rin_seen !== 16'd0) begin $display("FAIL illegal_rin: got %h want 0", rin_seen); n_fail++; end
    IR = IR_AND;
    pulse_start();
    n_checks++; if (illegal_op !== 1'b0) begin $display("FAIL illegal_clear: got %b want 0", illegal_op); n_fail++; end
    wait_idle("illegal");
  endtask

  task automatic test_back_to_back();
    IR = IR_ADD; mem_ready = 1'b1; run = 1'b1;
    pulse_start();
    for (int c = 1; c <= 18; c++) begin
      n_checks++;
      if (done !== ((c % 6) == 0)) begin $display("FAIL b2b_done_c%0d: got %b want %b", c, done, ((c % 6) == 0)); n_fail++; end
      if ((c % 6) == 5) begin
        n_checks++; if (alu_op !== 3'd1) begin $display("FAIL b2b_alu_op_c%0d: got %0d want 1", c, alu_op); n_fail++; end
      end
      if ((Rin != 16'd0) && (Rout != 16'd0)) begin
        $display("FAIL b2b_rin_rout_overlap_c%0d: Rin=%h Rout=%h", c, Rin, Rout); n_fail++;
      end
      if (c == 18) run = 1'b0;
      step();
    end
    n_checks++; if (busy !== 1'b0) begin $display("FAIL b2b_stop: busy=%b want 0", busy); n_fail++; end
  endtask

  task automatic test_reset_mid();
    logic [15:0] rin_seen;
    logic        busy_seen;
    IR = IR_ADD; mem_ready = 1'b1; run = 1'b0;
    pulse_start();
    rin_seen = Rin;
    for (int c = 2; c <= 5; c++) begin
      step();
      rin_seen |= Rin;
    end
    n_checks++; if ({alu_op, Zin} !== {3'd1, 1'b1}) begin $display("FAIL rstmid_in_t4: alu_op=%0d Zin=%b want 1/1", alu_op, Zin); n_fail++; end
    Reset = 1'b1;
    step();
    n_checks++; if ({busy, strobes} !== 12'd0) begin $display("FAIL rstmid_idle: busy=%b strobes=%h want 0", busy, strobes); n_fail++; end
    Reset = 1'b0;
    busy_seen = 1'b0;
    for (int c = 0; c < 3; c++) begin
      rin_seen |= Rin;
      busy_seen |= busy;
      step();
    end
    n_checks++; if (rin_seen !== 16'd0) begin $display("FAIL rstmid_rin: got %h want 0", rin_seen); n_fail++; end
    n_checks++; if (busy_seen !== 1'b0) begin $display("FAIL rstmid_stays_idle: busy seen %b want 0", busy_seen); n_fail++; end
  endtask

  initial begin
    test_reset();
    test_and();
    test_mem_wait();
    test_timeout();
    test_illegal();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
